// File: rtl/i281_memdisplay_scan.sv
`default_nettype none
// ============================================================================
// Module   : i281_memdisplay_scan
// Function : 8-digit multiplexed hex scanner showing one 4-byte page of the
//            i281 data memory, snapshotted tear-free at each frame start.
//            Optional macro I281_AUTO_PAGE_EN cycles pages automatically.
// Revision : 1.0  initial release
// ============================================================================
module i281_memdisplay_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int PAGE_HOLD   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] page_sel,
  input  logic       freeze,
  input  logic [7:0] datamem0,
  input  logic [7:0] datamem1,
  input  logic [7:0] datamem2,
  input  logic [7:0] datamem3,
  input  logic [7:0] datamem4,
  input  logic [7:0] datamem5,
  input  logic [7:0] datamem6,
  input  logic [7:0] datamem7,
  input  logic [7:0] datamem8,
  input  logic [7:0] datamem9,
  input  logic [7:0] datamem10,
  input  logic [7:0] datamem11,
  input  logic [7:0] datamem12,
  input  logic [7:0] datamem13,
  input  logic [7:0] datamem14,
  input  logic [7:0] datamem15,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [1:0] page_out
);

  localparam int                 c_cnt_w   = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_snap [4];
  logic [1:0]         r_page;
  logic [7:0]         r_an_n;
  logic [6:0]         r_seg_n;
  logic               r_dp_n;

  logic [7:0] w_mem [16];
  logic       w_frame_start;
  logic       w_cnt_wrap;
  logic       w_load;
  logic [1:0] w_page_new;
  logic [7:0] w_byte;
  logic [3:0] w_nib;
  logic [6:0] w_font;

  assign w_mem = '{datamem0, datamem1, datamem2,  datamem3,
                   datamem4, datamem5, datamem6,  datamem7,
                   datamem8, datamem9, datamem10, datamem11,
                   datamem12, datamem13, datamem14, datamem15};

  assign w_frame_start = (r_cnt == '0) && (r_idx == 3'd0);
  assign w_cnt_wrap    = (r_cnt == c_cnt_max);
  assign w_load        = w_frame_start && !freeze;

`ifdef I281_AUTO_PAGE_EN
  localparam int                  c_fcnt_w   = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
  localparam logic [c_fcnt_w-1:0] c_fcnt_max = c_fcnt_w'(PAGE_HOLD - 1);

  logic [c_fcnt_w-1:0] r_fcnt;
  logic                w_hold_done;
  logic                w_unused_page_sel;

  assign w_unused_page_sel = ^page_sel;
  assign w_hold_done       = (r_fcnt == c_fcnt_max);
  // The advanced page is used for the snapshot of the same frame.
  assign w_page_new        = w_hold_done ? r_page + 2'd1 : r_page;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
    end else if (w_load) begin
      r_fcnt <= w_hold_done ? '0 : r_fcnt + 1'b1;
    end
  end
`else
  assign w_page_new = page_sel;
`endif

  // Digit idx shows snap[3 - idx/2]; odd digits carry the high nibble.
  assign w_byte = r_snap[2'd3 - r_idx[2:1]];
  assign w_nib  = r_idx[0] ? w_byte[7:4] : w_byte[3:0];

  always_comb begin
    w_font = 7'h7F;
    case (w_nib)
      4'h0: w_font = 7'h40;
      4'h1: w_font = 7'h79;
      4'h2: w_font = 7'h24;
      4'h3: w_font = 7'h30;
      4'h4: w_font = 7'h19;
      4'h5: w_font = 7'h12;
      4'h6: w_font = 7'h02;
      4'h7: w_font = 7'h78;
      4'h8: w_font = 7'h00;
      4'h9: w_font = 7'h10;
      4'hA: w_font = 7'h08;
      4'hB: w_font = 7'h03;
      4'hC: w_font = 7'h46;
      4'hD: w_font = 7'h21;
      4'hE: w_font = 7'h06;
      4'hF: w_font = 7'h0E;
      default: w_font = 7'h7F;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_page  <= 2'd0;
      r_an_n  <= 8'hFF;
      r_seg_n <= 7'h7F;
      r_dp_n  <= 1'b1;
      for (int k = 0; k < 4; k++) r_snap[k] <= 8'h00;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) r_idx <= r_idx + 3'd1;
      if (w_load) begin
        r_page <= w_page_new;
        for (int k = 0; k < 4; k++) r_snap[k] <= w_mem[{w_page_new, k[1:0]}];
      end
      // First clock of every slot is blanked to suppress ghosting.
      r_an_n  <= (r_cnt == '0) ? 8'hFF : ~(8'h01 << r_idx);
      r_seg_n <= w_font;
      r_dp_n  <= !(freeze && (r_idx == 3'd0) && (r_cnt != '0));
    end
  end

  assign an_n     = r_an_n;
  assign seg_n    = r_seg_n;
  assign dp_n     = r_dp_n;
  assign page_out = r_page;

endmodule
`default_nettype wire

// File: tb/tb_i281_memdisplay_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_i281_memdisplay_scan
// Function : Directed self-checking bench for i281_memdisplay_scan
//            (REFRESH_DIV=4, default build without I281_AUTO_PAGE_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_i281_memdisplay_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] page_sel = 2'd0;
  logic       freeze = 1'b0;
  logic [7:0] dm [16];
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [1:0] page_out;

  int checks = 0;
  int errors = 0;

  i281_memdisplay_scan #(.REFRESH_DIV(4), .PAGE_HOLD(2)) dut (
    .clock(clock), .reset(reset), .page_sel(page_sel), .freeze(freeze),
    .datamem0(dm[0]),   .datamem1(dm[1]),   .datamem2(dm[2]),   .datamem3(dm[3]),
    .datamem4(dm[4]),   .datamem5(dm[5]),   .datamem6(dm[6]),   .datamem7(dm[7]),
    .datamem8(dm[8]),   .datamem9(dm[9]),   .datamem10(dm[10]), .datamem11(dm[11]),
    .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .page_out(page_out)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] font_exp(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one full frame starting just before its frame-start edge. w holds
  // {byte4p..byte4p+3}; digit i is expected to show w[4*i +: 4].
  task automatic run_frame(input logic [31:0] w, input logic [1:0] pg,
                           input logic dp_on, input int chg_at, input logic [1:0] chg_pg);
    logic [7:0] en;
    for (int i = 0; i < 8; i++) begin
      if (i == chg_at) page_sel = chg_pg;
      en = ~(8'h01 << i);
      step();
      chk("blank_an", an_n, 8'hFF);
      chk("blank_dp", {7'd0, dp_n}, 8'h01);
      if (i == 0) chk("page_out", {6'd0, page_out}, {6'd0, pg});
      step();
      chk("lit_an", an_n, en);
      chk("lit_seg", {1'b0, seg_n}, {1'b0, font_exp(w[4*i +: 4])});
      chk("lit_dp", {7'd0, dp_n}, (dp_on && i == 0) ? 8'h00 : 8'h01);
      step();
      step();
      chk("lit_end_an", an_n, en);
    end
  endtask

  initial begin
    dm = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
           8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    #2 reset = 1'b1;
    #1;
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", {1'b0, seg_n}, 8'h7F);
    chk("rst_dp", {7'd0, dp_n}, 8'h01);
    chk("rst_page", {6'd0, page_out}, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Page 0, then page_sel 0->2 at digit 3 must not disturb the current frame.
    run_frame(32'h12345678, 2'd0, 1'b0, -1, 2'd0);
    run_frame(32'h12345678, 2'd0, 1'b0, 3, 2'd2);
    chk("page_hold_midframe", {6'd0, page_out}, 8'h00);
    run_frame(32'h01234567, 2'd2, 1'b0, -1, 2'd0);
    page_sel = 2'd3;
    run_frame(32'h89ABCDEF, 2'd3, 1'b0, -1, 2'd0);
    page_sel = 2'd0;
    run_frame(32'h12345678, 2'd0, 1'b0, -1, 2'd0);

    // Frozen frame keeps old snapshot and page; dp lights on digit 0.
    freeze = 1'b1;
    dm[0] = 8'hAB;
    page_sel = 2'd1;
    run_frame(32'h12345678, 2'd0, 1'b1, -1, 2'd0);
    freeze = 1'b0;
    page_sel = 2'd0;
    run_frame(32'hAB345678, 2'd0, 1'b0, -1, 2'd0);

    page_sel = 2'd2;
    run_frame(32'h01234567, 2'd2, 1'b0, -1, 2'd0);

    // Asynchronous reset in the middle of a lit slot.
    repeat (5) step();
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_an", an_n, 8'hFF);
    chk("mid_rst_seg", {1'b0, seg_n}, 8'h7F);
    chk("mid_rst_dp", {7'd0, dp_n}, 8'h01);
    chk("mid_rst_page", {6'd0, page_out}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("post_rst_blank", an_n, 8'hFF);
    step();
    chk("post_rst_an", an_n, 8'hFE);
    chk("post_rst_seg", {1'b0, seg_n}, 8'h78);
    chk("post_rst_page", {6'd0, page_out}, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
